// File: rtl/draw_column_slice_if.sv
// Column-draw request / VGA pixel-write bundle between the column sequencer,
// the slice painter and the VGA adapter.
interface draw_column_slice_if;
    logic       start;
    logic [7:0] column;
    logic [6:0] slice_size;
    logic       side;
    logic       busy;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (
        output start, column, slice_size, side,
        input  busy, done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, column, slice_size, side,
        output busy, done, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/draw_column_slice.sv
// Paints one full screen column (ceiling, wall slice, floor) through the VGA
// pixel-write port at one pixel per clock, then pulses done.
module draw_column_slice #(
    parameter int          SCREEN_W      = 160,
    parameter int          SCREEN_H      = 120,
    parameter logic [2:0]  CEIL_COLOUR   = 3'b001,
    parameter logic [2:0]  FLOOR_COLOUR  = 3'b010,
    parameter logic [2:0]  WALL_COLOUR_H = 3'b111,
    parameter logic [2:0]  WALL_COLOUR_V = 3'b110
) (
    input  logic               clock,
    input  logic               resetn,
    draw_column_slice_if.slave bus
);

    localparam logic [8:0] W9       = 9'(SCREEN_W);
    localparam logic [7:0] H8       = 8'(SCREEN_H);
    localparam logic [7:0] LAST_ROW = H8 - 8'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAW,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [7:0] r_column;
    logic [6:0] r_size;
    logic       r_side;
    logic [7:0] r_top;
    logic [7:0] r_bot;
    logic [7:0] r_y;
    logic [7:0] r_vga_x;

    logic [7:0] w_h;
    logic [7:0] w_top;
    logic       w_visible;
    logic       w_plot;

    function automatic logic [7:0] clamp_height(input logic [6:0] size);
        logic [7:0] s;
        s = {1'b0, size};
        return (s > H8) ? H8 : s;
    endfunction

    function automatic logic [2:0] row_colour(input logic [7:0] y,
                                              input logic [7:0] top,
                                              input logic [7:0] bot,
                                              input logic       side);
        logic [2:0] c;
        if (y < top)
            c = CEIL_COLOUR;
        else if (y < bot)
            c = side ? WALL_COLOUR_V : WALL_COLOUR_H;
        else
            c = FLOOR_COLOUR;
        return c;
    endfunction

    // Odd leftover pixel lands below the slice because of the truncating shift.
    assign w_h       = clamp_height(r_size);
    assign w_top     = (H8 - w_h) >> 1;
    assign w_visible = ({1'b0, r_column} < W9);

    always_ff @(posedge clock) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (bus.start) w_next = S_LOAD;
            S_LOAD: w_next = w_visible ? S_DRAW : S_DONE;
            S_DRAW: if (r_y == LAST_ROW) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request and slice geometry; only meaningful once loaded, so no reset.
    always_ff @(posedge clock) begin
        if (r_state == S_IDLE && bus.start) begin
            r_column <= bus.column;
            r_size   <= bus.slice_size;
            r_side   <= bus.side;
        end
        if (r_state == S_LOAD) begin
            r_top <= w_top;
            r_bot <= w_top + w_h;
        end
    end

    // Row counter and pixel x double as the held vga_y / vga_x outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_y     <= 8'd0;
            r_vga_x <= 8'd0;
        end else if (r_state == S_LOAD && w_visible) begin
            r_y     <= 8'd0;
            r_vga_x <= r_column;
        end else if (r_state == S_DRAW && r_y != LAST_ROW) begin
            r_y     <= r_y + 8'd1;
        end
    end

    assign w_plot         = (r_state == S_DRAW);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.vga_plot   = w_plot;
    assign bus.vga_x      = r_vga_x;
    assign bus.vga_y      = r_y[6:0];
    assign bus.vga_colour = w_plot ? row_colour(r_y, r_top, r_bot, r_side) : 3'b000;

endmodule

// File: doc/draw_column_slice.md
# draw_column_slice

Downstream consumer of the slice-height calculator in the raycast maze renderer. Accepts one screen column index plus its projected wall-slice height. Paints that full column, top to bottom, through the VGA adapter's pixel-write port at one pixel per clock: ceiling colour above the slice, wall colour within it, floor colour below it. Signals completion so the column sequencer can advance to the next column.

## Interface
Parameters:
- SCREEN_W, 160, visible columns; columns >= SCREEN_W are never plotted
- SCREEN_H, 120, visible rows; slice heights are clamped to this value
- CEIL_COLOUR, 3'b001, colour of rows above the slice
- FLOOR_COLOUR, 3'b010, colour of rows below the slice
- WALL_COLOUR_H, 3'b111, wall colour when `side`=0 (horizontal-gridline hit)
- WALL_COLOUR_V, 3'b110, wall colour when `side`=1 (vertical-gridline hit)

Ports (reset: resetn, synchronous, active-low; clock: clock):
- clock  in  1  system clock, rising edge
- resetn  in  1  synchronous active-low reset
- start  in  1  request to draw one column; sampled only in IDLE
- column  in  8  screen x of the slice, unsigned
- slice_size  in  7  projected wall height in pixels, unsigned, 0..127
- side  in  1  wall orientation; selects the wall colour
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the column is finished
- vga_x  out  8  pixel x to the VGA adapter
- vga_y  out  7  pixel y to the VGA adapter
- vga_colour  out  3  pixel colour; 0 whenever vga_plot=0
- vga_plot  out  1  pixel write enable

## Operation
- States and transitions:
  - IDLE -> LOAD when start=1
  - LOAD -> DRAW when column < SCREEN_W
  - LOAD -> DONE when column >= SCREEN_W
  - DRAW -> DONE after the row with y = SCREEN_H-1 is plotted
  - DONE -> IDLE unconditionally
- IDLE, with start=1: latch column, slice_size and side into internal registers. Inputs may change freely afterwards.
- LOAD (1 cycle):
  - h = min(slice_size, SCREEN_H)
  - top = (SCREEN_H - h) >> 1, truncating, so any odd pixel goes below the slice
  - bot = top + h, exclusive bound
  - Clear the row counter y to 0
  - All arithmetic is unsigned, 8 bits wide internally; no overflow is possible
- DRAW, one row per cycle:
  - vga_plot=1, vga_x=latched column, vga_y=y
  - vga_colour = CEIL_COLOUR if y < top; wall colour if top <= y < bot; FLOOR_COLOUR otherwise
  - y increments each cycle
- DONE (1 cycle): done=1, vga_plot=0.
- start is ignored while busy=1, including in DONE. It is not queued.
- vga_x and vga_y hold their last values outside DRAW. vga_colour=0 and vga_plot=0 outside DRAW.

## Timing
- Reset: state=IDLE. busy, done, vga_plot, vga_x, vga_y and vga_colour are all 0 after the first clock edge with resetn=0.
- Reset mid-DRAW: at the reset edge, abandon the column, force vga_plot=0, and do not pulse done.
- start accepted at edge E0:
  - LOAD during cycle E0..E1
  - vga_plot high for exactly SCREEN_H consecutive cycles, E1..E1+SCREEN_H
  - done high during cycle E1+SCREEN_H..E1+SCREEN_H+1
  - busy high from E0 until the edge that ends DONE
- Start-to-done latency: SCREEN_H+2 cycles for a visible column; 2 cycles for an off-screen column.
- Throughput: the earliest next acceptance is at the edge ending DONE's successor IDLE cycle, giving a column period of SCREEN_H+3 cycles.
- Outputs are functions of registered state only, so there is no combinational path from inputs to outputs.

## Test plan
- Nominal: column=10, slice_size=40, side=0.
  - Required: 120 plots at x=10, y=0..119.
  - Rows 0..39 CEIL_COLOUR, rows 40..79 3'b111, rows 80..119 FLOOR_COLOUR.
  - done exactly 1 cycle after y=119.
- Odd and zero heights:
  - slice_size=7, side=1 gives wall rows 56..62 in 3'b110.
  - slice_size=0 gives rows 0..59 ceiling, rows 60..119 floor, and no wall pixel.
- Clamp: slice_size=127 gives all 120 rows wall colour. Same result for slice_size=120.
- Off-screen: column=200 gives no vga_plot pulse; done is asserted 2 cycles after acceptance.
- Handshake abuse:
  - Hold start=1 continuously with new inputs each cycle. Exactly one column is drawn per start accepted in IDLE, using the values latched at acceptance.
  - start pulses during DRAW and DONE are ignored.
- Reset mid-DRAW: assert resetn=0 when y=50.
  - Required next cycle: vga_plot=0, busy=0, no done pulse.
  - A subsequent start draws a complete fresh column from y=0.
